lbp_window_engine: RTL and testbench

LBP_WINDOW_ENGINE -- requirements
Module: lbp_window_engine

---
 rtl/lbp_window_engine.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_lbp_window_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_window_engine.sv
// lbp_window_engine: 3x3 local-binary-pattern engine over a 128x128 gray image.
// Fetches a window around the centre supplied by an external address counter,
// computes the 8-bit LBP code and hands it back with a one-cycle write pulse.
// Optional feature macro: LBP_WINDOW_REUSE_EN. When defined, windows after the
// first reuse six pixels of the previous window and fetch only the new row/column.
module lbp_window_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        gray_ready,
    output logic        gray_req,
    output logic [13:0] gray_addr,
    input  logic [7:0]  gray_data,
    input  logic [13:0] lbp_addr,
    input  logic        fill_right,
    input  logic        fill_down,
    input  logic        fill_left,
    output logic        lbp_addr_en,
    output logic        lbp_valid,
    output logic [7:0]  lbp_data,
    output logic        finish
);

    // Last centre of the serpentine scan; the write there ends the image.
    localparam logic [13:0] LastCentre = {7'd126, 7'd1};

    typedef enum logic [2:0] {
        StIdle,
        StFull,
        StPart,
        StCalc,
        StWrite,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ModeFull,
        ModeRight,
        ModeLeft,
        ModeDown
    } mode_e;

`ifdef LBP_WINDOW_REUSE_EN
    localparam state_e NextFetch = StPart;
`else
    localparam state_e NextFetch = StFull;
`endif

    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] centre_q, centre_d;
    // Slot of the read issued last cycle; its pixel lands this cycle.
    logic        cap_valid_q, cap_valid_d;
    logic [3:0]  cap_slot_q, cap_slot_d;
    // Window in raster order: slot 3*row + col, slot 4 is the centre.
    logic [7:0]  win_q [9];
    logic [7:0]  code_q, code_d;

    mode_e       flag_mode;
    mode_e       cur_mode;
    logic [13:0] cur_centre;
    logic [3:0]  part_slot;
    logic        rd_en;
    logic [3:0]  rd_slot;
    logic [6:0]  rd_row, rd_col;
    logic        shift_en;

`ifdef LBP_WINDOW_REUSE_EN
    // Decode the move direction; right beats left beats down, none means full fetch.
    always_comb begin
        flag_mode = ModeFull;
        if (fill_right) begin
            flag_mode = ModeRight;
        end else if (fill_left) begin
            flag_mode = ModeLeft;
        end else if (fill_down) begin
            flag_mode = ModeDown;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = ^{fill_right, fill_down, fill_left};

    // Without window reuse every fetch is a full one.
    always_comb begin
        flag_mode = ModeFull;
    end
`endif

    // Fetch context: the first fetch cycle takes the live centre and flags,
    // later cycles use the copies latched on that first cycle.
    always_comb begin
        cur_centre = (cnt_q == 4'd0) ? lbp_addr : centre_q;
        cur_mode   = (state_q == StPart && cnt_q == 4'd0) ? flag_mode : mode_q;
        case (cur_mode)
            ModeRight: part_slot = 4'd2 + 4'd3 * cnt_q;
            ModeLeft:  part_slot = 4'd3 * cnt_q;
            ModeDown:  part_slot = 4'd6 + cnt_q;
            default:   part_slot = 4'd0;
        endcase
    end

    // Next-state and control outputs.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        centre_d    = centre_q;
        cap_valid_d = 1'b0;
        cap_slot_d  = cap_slot_q;
        rd_en       = 1'b0;
        rd_slot     = 4'd0;
        shift_en    = 1'b0;
        lbp_valid   = 1'b0;
        lbp_addr_en = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (gray_ready) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (cnt_q == 4'd0) begin
                    centre_d = lbp_addr;
                end
                if (cnt_q <= 4'd8) begin
                    rd_en   = 1'b1;
                    rd_slot = cnt_q;
                end
                if (cnt_q == 4'd9) begin
                    state_d = StCalc;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StPart: begin
                if (cnt_q == 4'd0) begin
                    centre_d = lbp_addr;
                    mode_d   = flag_mode;
                end
                if (cur_mode == ModeFull) begin
                    // No move recorded: this cycle becomes the first read of a full fetch.
                    rd_en   = 1'b1;
                    rd_slot = 4'd0;
                    state_d = StFull;
                    cnt_d   = 4'd1;
                end else begin
                    shift_en = (cnt_q == 4'd0);
                    if (cnt_q <= 4'd2) begin
                        rd_en   = 1'b1;
                        rd_slot = part_slot;
                    end
                    if (cnt_q == 4'd3) begin
                        state_d = StCalc;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StCalc: begin
                state_d = StWrite;
            end
            StWrite: begin
                lbp_valid   = 1'b1;
                lbp_addr_en = 1'b1;
                cnt_d       = 4'd0;
                state_d     = (lbp_addr == LastCentre) ? StDone : NextFetch;
            end
            StDone: begin
                finish = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rd_en) begin
            cap_valid_d = 1'b1;
            cap_slot_d  = rd_slot;
        end
    end

    // Read address: slot row/column offsets applied to the held centre.
    always_comb begin
        rd_row = cur_centre[13:7];
        rd_col = cur_centre[6:0];
        case (rd_slot)
            4'd0, 4'd1, 4'd2: rd_row = cur_centre[13:7] - 7'd1;
            4'd6, 4'd7, 4'd8: rd_row = cur_centre[13:7] + 7'd1;
            default:          rd_row = cur_centre[13:7];
        endcase
        case (rd_slot)
            4'd0, 4'd3, 4'd6: rd_col = cur_centre[6:0] - 7'd1;
            4'd2, 4'd5, 4'd8: rd_col = cur_centre[6:0] + 7'd1;
            default:          rd_col = cur_centre[6:0];
        endcase
        gray_req  = rd_en;
        gray_addr = rd_en ? {rd_row, rd_col} : 14'd0;
    end

    // LBP code: bit k set when neighbour k is not below the centre.
    always_comb begin
        code_d[0] = (win_q[0] >= win_q[4]);
        code_d[1] = (win_q[1] >= win_q[4]);
        code_d[2] = (win_q[2] >= win_q[4]);
        code_d[3] = (win_q[3] >= win_q[4]);
        code_d[4] = (win_q[5] >= win_q[4]);
        code_d[5] = (win_q[6] >= win_q[4]);
        code_d[6] = (win_q[7] >= win_q[4]);
        code_d[7] = (win_q[8] >= win_q[4]);
    end

    // FSM and fetch bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= ModeFull;
            cnt_q       <= 4'd0;
            centre_q    <= 14'd0;
            cap_valid_q <= 1'b0;
            cap_slot_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            centre_q    <= centre_d;
            cap_valid_q <= cap_valid_d;
            cap_slot_q  <= cap_slot_d;
        end
    end

    // Window registers: shift on a partial fetch, then capture returning pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= 8'd0;
            end
        end else begin
            if (shift_en) begin
                case (cur_mode)
                    ModeRight: begin
                        win_q[0] <= win_q[1];
                        win_q[1] <= win_q[2];
                        win_q[3] <= win_q[4];
                        win_q[4] <= win_q[5];
                        win_q[6] <= win_q[7];
                        win_q[7] <= win_q[8];
                    end
                    ModeLeft: begin
                        win_q[2] <= win_q[1];
                        win_q[1] <= win_q[0];
                        win_q[5] <= win_q[4];
                        win_q[4] <= win_q[3];
                        win_q[8] <= win_q[7];
                        win_q[7] <= win_q[6];
                    end
                    ModeDown: begin
                        win_q[0] <= win_q[3];
                        win_q[1] <= win_q[4];
                        win_q[2] <= win_q[5];
                        win_q[3] <= win_q[6];
                        win_q[4] <= win_q[7];
                        win_q[5] <= win_q[8];
                    end
                    default: begin
                    end
                endcase
            end
            if (cap_valid_q) begin
                win_q[cap_slot_q] <= gray_data;
            end
        end
    end

    // Output code register, loaded in CALC and held through WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= 8'd0;
        end else if (state_q == StCalc) begin
            code_q <= code_d;
        end
    end

    assign lbp_data = code_q;

endmodule

// File: tb/tb_lbp_window_engine.sv
// Self-checking bench for lbp_window_engine: random image, serpentine address
// counter model, and a reference that derives reads and codes from pixel positions.
module tb_lbp_window_engine;

`ifdef LBP_WINDOW_REUSE_EN
    localparam bit Reuse = 1'b1;
`else
    localparam bit Reuse = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic [13:0] lbp_addr;
    logic        fill_right, fill_down, fill_left;
    logic        lbp_addr_en, lbp_valid, finish;
    logic [7:0]  lbp_data;

    always #5 clk = ~clk;

    lbp_window_engine dut (
        .clk         (clk),
        .reset       (reset),
        .gray_ready  (gray_ready),
        .gray_req    (gray_req),
        .gray_addr   (gray_addr),
        .gray_data   (gray_data),
        .lbp_addr    (lbp_addr),
        .fill_right  (fill_right),
        .fill_down   (fill_down),
        .fill_left   (fill_left),
        .lbp_addr_en (lbp_addr_en),
        .lbp_valid   (lbp_valid),
        .lbp_data    (lbp_data),
        .finish      (finish)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source image with a one-cycle read latency.
    logic [7:0] img [16384];
    always @(posedge clk) gray_data <= img[gray_addr];

    // Serpentine address counter: odd rows run right, even rows run left.
    int start_row = 1;
    int start_col = 1;
    int cnt_row, cnt_col;
    always @(posedge clk) begin
        if (reset) begin
            cnt_row    <= start_row;
            cnt_col    <= start_col;
            fill_right <= 1'b0;
            fill_left  <= 1'b0;
            fill_down  <= 1'b0;
        end else if (lbp_addr_en) begin
            fill_right <= 1'b0;
            fill_left  <= 1'b0;
            fill_down  <= 1'b0;
            if (cnt_row % 2 == 1) begin
                if (cnt_col < 126) begin
                    cnt_col    <= cnt_col + 1;
                    fill_right <= 1'b1;
                end else begin
                    cnt_row   <= cnt_row + 1;
                    fill_down <= 1'b1;
                end
            end else begin
                if (cnt_col > 1) begin
                    cnt_col   <= cnt_col - 1;
                    fill_left <= 1'b1;
                end else begin
                    cnt_row   <= cnt_row + 1;
                    fill_down <= 1'b1;
                end
            end
        end
    end
    assign lbp_addr = {cnt_row[6:0], cnt_col[6:0]};

    // Reference LBP code straight from the image.
    function automatic int ref_code(input int r, input int c);
        int dr [8];
        int dc [8];
        int code;
        dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
        dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
        code = 0;
        for (int k = 0; k < 8; k++) begin
            if (img[(r + dr[k]) * 128 + c + dc[k]] >= img[r * 128 + c]) code += (1 << k);
        end
        return code;
    endfunction

    int exp_q [$];

    // Expected read addresses for a window: 0 full, 1 right, 2 left, 3 down.
    task automatic build_expected(input int r, input int c, input int mode);
        exp_q.delete();
        for (int i = -1; i <= 1; i++) begin
            case (mode)
                1: exp_q.push_back((r + i) * 128 + c + 1);
                2: exp_q.push_back((r + i) * 128 + c - 1);
                3: exp_q.push_back((r + 1) * 128 + c + i);
                default: for (int j = -1; j <= 1; j++) exp_q.push_back((r + i) * 128 + c + j);
            endcase
        end
    endtask

    int cyc = 0;
    int last_valid_cyc = 0;
    int first_req_cyc = -1;
    bit first_win = 1'b1;
    int valid_cnt = 0;
    int addr_bad = 0;
    int done_bad = 0;
    int rd_q [$];

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int r, c, mode;
        cyc++;
        if (reset) begin
            first_win     = 1'b1;
            first_req_cyc = -1;
            rd_q.delete();
        end else begin
            if (gray_req) begin
                rd_q.push_back(int'(gray_addr));
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end else if (gray_addr != 14'd0) begin
                addr_bad++;
            end
            if (finish && (gray_req || lbp_valid || lbp_addr_en)) done_bad++;
            if (lbp_valid) begin
                r = int'(lbp_addr[13:7]);
                c = int'(lbp_addr[6:0]);
                mode = 0;
                if (Reuse && !first_win) begin
                    if (fill_right) mode = 1;
                    else if (fill_left) mode = 2;
                    else if (fill_down) mode = 3;
                end
                build_expected(r, c, mode);
                check("num_reads", rd_q.size(), exp_q.size());
                for (int i = 0; i < exp_q.size(); i++) begin
                    check("read_addr", (i < rd_q.size()) ? rd_q[i] : -1, exp_q[i]);
                end
                check("lbp_data", int'(lbp_data), ref_code(r, c));
                check("addr_en_with_valid", int'(lbp_addr_en), 1);
                if (lbp_addr == {7'd1, 7'd5}) check("directed_code", int'(lbp_data), 8'hB6);
                if (first_win) check("first_latency", cyc - first_req_cyc, 11);
                else check("window_period", cyc - last_valid_cyc, Reuse ? 6 : 12);
                check("gray_addr_when_idle", addr_bad, 0);
                last_valid_cyc = cyc;
                first_win = 1'b0;
                rd_q.delete();
                valid_cnt++;
            end
        end
    end

    task automatic wait_valids(input int n, input int budget);
        int base;
        int k;
        base = valid_cnt;
        k = 0;
        while (valid_cnt - base < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("valid_wait_timeout", int'(valid_cnt - base >= n), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gray_req"}, int'(gray_req), 0);
        check({tag, "_gray_addr"}, int'(gray_addr), 0);
        check({tag, "_lbp_valid"}, int'(lbp_valid), 0);
        check({tag, "_lbp_addr_en"}, int'(lbp_addr_en), 0);
        check({tag, "_lbp_data"}, int'(lbp_data), 0);
        check({tag, "_finish"}, int'(finish), 0);
    endtask

    initial begin
        int k;
        int req_seen;
        int seg_base;

        // Rows 2..4 use a tiny value range so equal-to-centre cases are common.
        for (int a = 0; a < 16384; a++) begin
            if ((a / 128) >= 2 && (a / 128) <= 4) img[a] = 8'($urandom_range(0, 3));
            else img[a] = 8'($urandom);
        end
        img[0 * 128 + 4] = 8'd99;
        img[0 * 128 + 5] = 8'd100;
        img[0 * 128 + 6] = 8'd101;
        img[1 * 128 + 4] = 8'd50;
        img[1 * 128 + 5] = 8'd100;
        img[1 * 128 + 6] = 8'd200;
        img[2 * 128 + 4] = 8'd100;
        img[2 * 128 + 5] = 8'd0;
        img[2 * 128 + 6] = 8'd255;

        reset = 1'b1;
        gray_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // No source image yet: the engine must stay idle.
        req_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (gray_req) req_seen++;
        end
        check("idle_without_ready", req_seen, 0);

        // Main run across row 1, the turn at column 126 and into row 3.
        gray_ready = 1'b1;
        wait_valids(260, 260 * 13 + 50);
        check("no_finish_midrun", int'(finish), 0);

        // Reset in the middle of a fetch.
        k = 0;
        @(negedge clk);
        while (!gray_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("fetch_seen", int'(gray_req), 1);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midfetch_reset");
        reset = 1'b0;
        wait_valids(6, 6 * 13 + 50);

        // Reset during WRITE suppresses the following pulse.
        k = 0;
        @(negedge clk);
        while (!lbp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("write_seen", int'(lbp_valid), 1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("write_reset");

        // Finish at the last centre of the serpentine scan.
        start_row = 126;
        start_col = 4;
        @(posedge clk);
        #1 reset = 1'b0;
        seg_base = valid_cnt;
        wait_valids(4, 4 * 13 + 50);
        repeat (30) @(posedge clk);
        #1;
        check("finish_high", int'(finish), 1);
        check("pulses_to_finish", valid_cnt - seg_base, 4);
        check("quiet_after_finish", done_bad, 0);
        check("gray_req_after_finish", int'(gray_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
